led_pattern_anim: RTL and testbench
===================================

// Module: led_pattern_anim
// PURPOSE
//  Parametrised LED animation engine, successor to the fixed 10-LED level-start sweep.
//  Runs one of four patterns (sweep up, sweep down, bounce, fill) over NUM_LEDS lights.
//  Holds each step for a programmable fraction of a second and repeats the pattern a set
//  number of passes. Signals completion to the game FSM with a one-cycle done pulse.
//  Self-timed: the internal tick counter replaces the external Timer instance.
// PARAMETERS
//  NUM_LEDS         10        number of lights driven; must be >= 2
//  CLOCK_FREQUENCY  50000000  clock rate in Hz
//  STEPS_PER_SEC    4         pattern steps per second; STEP_CYCLES = CLOCK_FREQUENCY/STEPS_PER_SEC, must be >= 1
// PORTS
//  clock    in   1         system clock, all logic on rising edge
//  resetn   in   1         asynchronous, active-low reset
//  start    in   1         level-sampled; starts a run when the block is idle
//  abort    in   1         synchronous; terminates a run with no done pulse
//  mode     in   2         0 SWEEP_UP, 1 SWEEP_DOWN, 2 BOUNCE, 3 FILL; latched on start
//  repeats  in   4         pass count; 0 is treated as 1; latched on start
//  lights   out  NUM_LEDS  registered LED pattern
//  busy     out  1         high while in RUN
//  done     out  1         one-cycle pulse after the final step completes
//  pass_num out  4         current pass, 0-based (debug)
// BEHAVIOUR
//  Reset (resetn=0, any time, including mid-run): state=IDLE; lights, busy, done, pass_num,
//   and the tick and step counters all 0. Latched mode and repeats are cleared.
//  States: IDLE -> RUN -> DONE -> IDLE. RUN -> IDLE on abort. All outputs are registered.
//  IDLE: on a clock edge with start=1 and abort=0, latch mode and repeats (P = repeats ? repeats : 1).
//   Clear counters. In the next cycle, lights = step 0 pattern and busy = 1. Latency is 1 cycle.
//  RUN: the tick counter counts 0..STEP_CYCLES-1. Each pattern is held exactly STEP_CYCLES cycles.
//   At terminal tick: if this is not the last step of the pass, advance the step.
//   Else if pass_num < P-1, increment pass_num and restart at step 0.
//   Else go to DONE.
//  Step patterns, k = step index within a pass, N = NUM_LEDS:
//   SWEEP_UP:   N steps, lights = 1<<k
//   SWEEP_DOWN: N steps, lights = 1<<(N-1-k)
//   BOUNCE:     2N-2 steps; lights = 1<<k for k<N, else 1<<(2N-2-k)
//               (0..N-1..1; endpoints are not doubled across passes)
//   FILL:       N steps, lights = (1<<(k+1))-1 (bar graph, all lit on last step)
//  DONE: lasts 1 cycle. lights = 0, busy = 0, done = 1, pass_num = 0. The next state is IDLE.
//   start is ignored in DONE, so a new run can begin on the cycle after done at the earliest.
//  Run length from the first lit cycle to the done cycle is steps_per_pass*P*STEP_CYCLES cycles.
//  start while busy or in DONE: ignored. Changes to mode or repeats mid-run: ignored.
//  abort in RUN: next cycle is IDLE with lights = 0, busy = 0, and no done pulse.
//   abort has priority over the terminal tick in the same cycle.
//   abort in IDLE with start=1 in the same cycle: abort wins and no run starts.
//  Counter widths: the tick counter is $clog2(STEP_CYCLES+1) bits.
//   The step counter is $clog2(2*NUM_LEDS) bits. Neither counter may wrap unintentionally.
// TESTING (NUM_LEDS=4, CLOCK_FREQUENCY=8, STEPS_PER_SEC=2, so STEP_CYCLES=4)
//  1. Assert resetn=0, then release -> lights=0000, busy=0, done=0. Pulse resetn low mid-run
//     -> all outputs 0 immediately (asynchronously).
//  2. start, mode=0, repeats=1 -> 0001,0010,0100,1000, 4 cycles each, busy=1 for 16 cycles;
//     next cycle lights=0000, done=1 for exactly 1 cycle.
//  3. mode=2, repeats=2 -> 1,2,4,8,4,2,1,2,4,8,4,2 (hex), 4 cycles each, pass_num 0 then 1;
//     done at cycle 49 after start.
//  4. mode=3, repeats=0 -> 0001,0011,0111,1111, then done; mode=1 -> 1000,0100,0010,0001.
//  5. Mid-run: toggle mode, repeats, and start -> sequence is unchanged. Assert abort at cycle 6
//     -> lights=0000, busy=0 at cycle 7, done never asserted.
//  6. abort at the terminal tick of the final step -> no done. start+abort together in IDLE
//     -> no run. start held high continuously -> a new run begins 1 cycle after each done.

Source files
------------

// File: rtl/led_pattern_anim.sv
// rtl/led_pattern_anim.sv - self-timed LED animation engine (sweep up/down, bounce, fill)
module led_pattern_anim #(
    parameter int NUM_LEDS        = 10,
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int STEPS_PER_SEC   = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [3:0]          repeats,
    output logic [NUM_LEDS-1:0] lights,
    output logic                busy,
    output logic                done,
    output logic [3:0]          pass_num
);

    localparam int STEP_CYCLES = CLOCK_FREQUENCY / STEPS_PER_SEC;
    localparam int TW          = $clog2(STEP_CYCLES + 1);
    localparam int SW          = $clog2(2 * NUM_LEDS);

    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] LAST_LIN  = SW'(NUM_LEDS - 1);
    localparam logic [SW-1:0] LAST_BNC  = SW'(2 * NUM_LEDS - 3);

    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q,     state_d;
    logic [TW-1:0]       tick_q,      tick_d;
    logic [SW-1:0]       step_q,      step_d;
    logic [3:0]          pass_q,      pass_d;
    logic [3:0]          last_pass_q, last_pass_d;
    logic [1:0]          mode_q,      mode_d;
    logic [NUM_LEDS-1:0] lights_q,    lights_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    // LED image for step k of a pass in pattern m
    function automatic logic [NUM_LEDS-1:0] step_pattern(input logic [1:0] m, input logic [SW-1:0] k);
        logic [NUM_LEDS-1:0] one;
        logic [NUM_LEDS-1:0] p;
        int                  idx;
        one = NUM_LEDS'(1);
        idx = int'(k);
        case (m)
            2'd0:    p = one << idx;
            2'd1:    p = one << (NUM_LEDS - 1 - idx);
            2'd2:    p = (idx < NUM_LEDS) ? (one << idx) : (one << (2 * NUM_LEDS - 2 - idx));
            default: begin
                // shifting past the top yields 0, so the final step wraps to all ones
                p = one << (idx + 1);
                p = p - one;
            end
        endcase
        return p;
    endfunction

    function automatic logic [SW-1:0] last_step(input logic [1:0] m);
        return (m == MODE_BOUNCE) ? LAST_BNC : LAST_LIN;
    endfunction

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        step_d      = step_q;
        pass_d      = pass_q;
        last_pass_d = last_pass_q;
        mode_d      = mode_q;
        lights_d    = lights_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    mode_d      = mode;
                    last_pass_d = (repeats == 4'd0) ? 4'd0 : repeats - 4'd1;
                    tick_d      = '0;
                    step_d      = '0;
                    pass_d      = '0;
                    lights_d    = step_pattern(mode, '0);
                    busy_d      = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    tick_d   = '0;
                    step_d   = '0;
                    pass_d   = '0;
                    lights_d = '0;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (step_q != last_step(mode_q)) begin
                        step_d   = step_q + SW'(1);
                        lights_d = step_pattern(mode_q, step_q + SW'(1));
                    end else if (pass_q < last_pass_q) begin
                        pass_d   = pass_q + 4'd1;
                        step_d   = '0;
                        lights_d = step_pattern(mode_q, '0);
                    end else begin
                        step_d   = '0;
                        pass_d   = '0;
                        lights_d = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                // single-cycle DONE; start is deliberately not looked at here
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            step_q      <= '0;
            pass_q      <= '0;
            last_pass_q <= '0;
            mode_q      <= '0;
            lights_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            step_q      <= step_d;
            pass_q      <= pass_d;
            last_pass_q <= last_pass_d;
            mode_q      <= mode_d;
            lights_q    <= lights_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign lights   = lights_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_num = pass_q;

endmodule

// File: tb/tb_led_pattern_anim.sv
// tb/tb_led_pattern_anim.sv - directed self-checking bench for led_pattern_anim
module tb_led_pattern_anim;

    logic       clock;
    logic       resetn;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [3:0] repeats;
    logic [3:0] lights;
    logic       busy;
    logic       done;
    logic [3:0] pass_num;

    int checks = 0;
    int errors = 0;

    led_pattern_anim #(
        .NUM_LEDS(4),
        .CLOCK_FREQUENCY(8),
        .STEPS_PER_SEC(2)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .abort(abort),
        .mode(mode),
        .repeats(repeats),
        .lights(lights),
        .busy(busy),
        .done(done),
        .pass_num(pass_num)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one cycle; observation point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; repeats = 4'd1;
        tick(); tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (lights !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || pass_num !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: lights=%b busy=%b done=%b pass=%0d, want 0000 0 0 0", lights, busy, done, pass_num);
        end
        // asynchronous reset in the middle of a run
        mode = 2'd0; repeats = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (lights !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_async_reset: lights=%b busy=%b, want 0010 1", lights, busy);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (lights !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || pass_num !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: lights=%b busy=%b done=%b pass=%0d, want all 0", lights, busy, done, pass_num);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_sweep_up();
        logic [3:0] exp_seq [0:3] = '{4'h1, 4'h2, 4'h4, 4'h8};
        mode = 2'd0; repeats = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (lights !== exp_seq[c/4] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL sweep_up cyc%0d: lights=%b busy=%b done=%b, want %b 1 0", c + 1, lights, busy, done, exp_seq[c/4]);
            end
            tick();
        end
        checks++;
        if (lights !== 4'b0000 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL sweep_up_done: lights=%b busy=%b done=%b, want 0000 0 1", lights, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_up_done_width: done=%b, want 0", done);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_seq [0:5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
        mode = 2'd2; repeats = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 48; c++) begin
            checks++;
            if (lights !== exp_seq[(c/4)%6] || pass_num !== 4'(c/24) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL bounce cyc%0d: lights=%h pass=%0d busy=%b done=%b, want %h %0d 1 0",
                         c + 1, lights, pass_num, busy, done, exp_seq[(c/4)%6], c/24);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || lights !== 4'h0 || pass_num !== 4'd0) begin
            errors++;
            $display("FAIL bounce_done_cyc49: done=%b lights=%h pass=%0d, want 1 0 0", done, lights, pass_num);
        end
        tick();
    endtask

    task automatic test_fill_and_down();
        logic [3:0] exp_seq [0:7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                      4'b1000, 4'b0100, 4'b0010, 4'b0001};
        logic [1:0] modes [0:1] = '{2'd3, 2'd1};
        for (int m = 0; m < 2; m++) begin
            mode = modes[m]; repeats = 4'd0; start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 16; c++) begin
                checks++;
                if (lights !== exp_seq[m*4 + c/4] || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL mode%0d cyc%0d: lights=%b busy=%b, want %b 1", modes[m], c + 1, lights, busy, exp_seq[m*4 + c/4]);
                end
                tick();
            end
            checks++;
            if (done !== 1'b1 || lights !== 4'b0000) begin
                errors++;
                $display("FAIL mode%0d_done: done=%b lights=%b, want 1 0000", modes[m], done, lights);
            end
            tick();
        end
    endtask

    task automatic test_mid_run_ignore_abort();
        logic [3:0] exp_seq [0:5] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2};
        int         saw_done = 0;
        mode = 2'd0; repeats = 4'd1; start = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            mode = 2'(c + 1); repeats = 4'(c + 5); start = ~start;
            checks++;
            if (lights !== exp_seq[c]) begin
                errors++;
                $display("FAIL mid_run cyc%0d: lights=%b, want %b", c + 1, lights, exp_seq[c]);
            end
            if (c == 5) begin
                start = 1'b0;
                abort = 1'b1;
            end
            tick();
        end
        abort = 1'b0;
        checks++;
        if (lights !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_cyc7: lights=%b busy=%b done=%b, want 0000 0 0", lights, busy, done);
        end
        for (int c = 0; c < 20; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done++;
            tick();
        end
        checks++;
        if (saw_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d cycles with done/busy set, want 0", saw_done);
        end
    endtask

    task automatic test_abort_edge_cases();
        int bad = 0;
        mode = 2'd0; repeats = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 15; c++) tick();
        checks++;
        if (lights !== 4'b1000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL final_step: lights=%b busy=%b, want 1000 1", lights, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || lights !== 4'b0000) begin
            errors++;
            $display("FAIL abort_terminal: done=%b busy=%b lights=%b, want 0 0 0000", done, busy, lights);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_terminal_late_done: done=%b, want 0", done);
        end
        start = 1'b1; abort = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (busy !== 1'b0 || lights !== 4'b0000) bad++;
        end
        start = 1'b0; abort = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL start_abort_idle: %0d cycles busy/lit, want 0", bad);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        mode = 2'd1; repeats = 4'd1; start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            checks++;
            if (lights !== 4'b1000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_run%0d_first: lights=%b busy=%b, want 1000 1", r, lights, busy);
            end
            for (int c = 0; c < 16; c++) tick();
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_run%0d_done: done=%b busy=%b, want 1 0", r, done, busy);
            end
            tick();
            checks++;
            if (busy !== 1'b0 || lights !== 4'b0000 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_run%0d_gap: busy=%b lights=%b done=%b, want 0 0000 0", r, busy, lights, done);
            end
        end
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cleanup: busy=%b, want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_sweep_up();
        test_bounce();
        test_fill_and_down();
        test_mid_run_ignore_abort();
        test_abort_edge_cases();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
